// File: rtl/data_sram_responder.sv
// Single-port 32-bit data SRAM responder with addr_ok/data_ok handshake.
// Requests are accepted one at a time; each response arrives a fixed LATENCY cycles after acceptance.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    pend_rd_q;
  logic [31:0]             hold_q;
  logic [31:0]             rdata_q;
  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    accept;
  logic                    unused_addr_bits;

  assign idx              = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  assign data_sram_addr_ok = (state_q != BUSY);
  assign data_sram_data_ok = (state_q == RESP);
  assign data_sram_rdata   = rdata_q;

  // A request presented while reset is high is neither accepted nor written.
  assign accept = data_sram_req && data_sram_addr_ok && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_rd_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pend_rd_q <= !data_sram_wr;
      end
      // rdata only changes on entry to RESP for a read; writes leave it untouched.
      if (LATENCY == 1) begin
        if (accept && !data_sram_wr) begin
          rdata_q <= mem[idx];
        end
      end else if (state_q == BUSY && state_d == RESP && pend_rd_q) begin
        rdata_q <= hold_q;
      end
    end
  end

  // Storage and the read holding register are never reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
    if (accept && !data_sram_wr) begin
      hold_q <= mem[idx];
    end
  end

endmodule
